// File: rtl/mbist_serial_slave_pkg.sv
// Shared definitions for the MBIST serial slave: FSM encoding, default widths and IR codes.
package mbist_serial_slave_pkg;

  localparam int IR_WIDTH_DEF          = 2;
  localparam int CMD_WIDTH_DEF         = 1;
  localparam int RESULT_WIDTH_DEF      = 2;
  localparam int COMMAND_IR_ID_DEF     = 1;
  localparam int TEST_RESULT_IR_ID_DEF = 2;

  localparam logic [1:0] ST_IR_IDLE  = 2'd0;
  localparam logic [1:0] ST_IR_SHIFT = 2'd1;
  localparam logic [1:0] ST_DR_IDLE  = 2'd2;
  localparam logic [1:0] ST_DR_SHIFT = 2'd3;

  typedef enum logic [1:0] {
    IR_IDLE  = ST_IR_IDLE,
    IR_SHIFT = ST_IR_SHIFT,
    DR_IDLE  = ST_DR_IDLE,
    DR_SHIFT = ST_DR_SHIFT
  } state_e;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mbist_serial_shreg.sv
// Right-shifting register with parallel load; new bits enter at the MSB.
// nextLsb_o exposes the LSB the register will hold after the coming edge.
module mbist_serial_shreg #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] loadVal_i,
  input  logic             shift_i,
  input  logic             shiftIn_i,
  output logic [WIDTH-1:0] q_o,
  output logic             nextLsb_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = loadVal_i;
    end else if (shift_i) begin
      data_d            = data_q >> 1;
      data_d[WIDTH-1]   = shiftIn_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o       = data_q;
  assign nextLsb_o = data_d[0];

endmodule

// File: rtl/mbist_serial_slave.sv
// SCK-domain serial responder: IR-select frame followed by a command-in or result-out data frame.
module mbist_serial_slave
  import mbist_serial_slave_pkg::*;
#(
  parameter int IR_WIDTH          = IR_WIDTH_DEF,
  parameter int CMD_WIDTH         = CMD_WIDTH_DEF,
  parameter int RESULT_WIDTH      = RESULT_WIDTH_DEF,
  parameter int COMMAND_IR_ID     = COMMAND_IR_ID_DEF,
  parameter int TEST_RESULT_IR_ID = TEST_RESULT_IR_ID_DEF
) (
  input  logic                    SCK,
  input  logic                    SRST,
  input  logic                    SEN,
  input  logic                    SDI,
  output logic                    SDO,
  input  logic [RESULT_WIDTH-1:0] result_in,
  output logic [CMD_WIDTH-1:0]    cmd_out,
  output logic                    cmd_update,
  output logic [IR_WIDTH-1:0]     ir_out,
  output logic                    frame_err
);

  localparam int CNT_MAX = maxInt(IR_WIDTH, CMD_WIDTH) + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]    CNT_SAT = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0]    IR_LEN  = CNT_W'(IR_WIDTH);
  localparam logic [CNT_W-1:0]    CMD_LEN = CNT_W'(CMD_WIDTH);
  localparam logic [IR_WIDTH-1:0] CMD_ID  = IR_WIDTH'(COMMAND_IR_ID);
  localparam logic [IR_WIDTH-1:0] RES_ID  = IR_WIDTH'(TEST_RESULT_IR_ID);

  state_e                state_q;
  logic [CNT_W-1:0]      bitCnt_q;
  logic [CNT_W-1:0]      bitCntInc;
  logic [IR_WIDTH-1:0]   ir_q;
  logic [CMD_WIDTH-1:0]  cmd_q;
  logic                  cmdUpdate_q;
  logic                  frameErr_q;
  logic                  sdo_q;
  logic                  sdo_d;

  logic                    isCmd, isResult, isBypass;
  logic                    irShiftEn, drShiftEn, resLoad;
  logic [IR_WIDTH-1:0]     irShadow;
  logic [CMD_WIDTH-1:0]    cmdShadow;
  logic [RESULT_WIDTH-1:0] resReg;
  logic                    irNextLsb, cmdNextLsb, resNextLsb;
  logic                    unusedBits;

  assign unusedBits = irNextLsb ^ cmdNextLsb ^ (^resReg);

  always_comb begin
    isCmd     = (ir_q == CMD_ID);
    isResult  = (ir_q == RES_ID);
    isBypass  = !isCmd && !isResult;
    irShiftEn = SEN && (state_q == IR_IDLE || state_q == IR_SHIFT);
    drShiftEn = SEN && (state_q == DR_IDLE || state_q == DR_SHIFT);
    resLoad   = isResult && (state_q == DR_IDLE) && !SEN;
    bitCntInc = (bitCnt_q == CNT_SAT) ? CNT_SAT : bitCnt_q + CNT_W'(1);
  end

  // SDO is registered, so it is fed with the value the selected source will present after this edge.
  always_comb begin
    sdo_d = 1'b0;
    if (isResult && (state_q == DR_IDLE || (state_q == DR_SHIFT && SEN))) begin
      sdo_d = resNextLsb;
    end else if (isBypass && drShiftEn) begin
      sdo_d = SDI;
    end
  end

  mbist_serial_shreg #(.WIDTH(IR_WIDTH)) irShreg (
    .clk       (SCK),
    .rst       (SRST),
    .load_i    (1'b0),
    .loadVal_i ('0),
    .shift_i   (irShiftEn),
    .shiftIn_i (SDI),
    .q_o       (irShadow),
    .nextLsb_o (irNextLsb)
  );

  mbist_serial_shreg #(.WIDTH(CMD_WIDTH)) cmdShreg (
    .clk       (SCK),
    .rst       (SRST),
    .load_i    (1'b0),
    .loadVal_i ('0),
    .shift_i   (drShiftEn && isCmd),
    .shiftIn_i (SDI),
    .q_o       (cmdShadow),
    .nextLsb_o (cmdNextLsb)
  );

  mbist_serial_shreg #(.WIDTH(RESULT_WIDTH)) resShreg (
    .clk       (SCK),
    .rst       (SRST),
    .load_i    (resLoad),
    .loadVal_i (result_in),
    .shift_i   (drShiftEn && isResult),
    .shiftIn_i (1'b0),
    .q_o       (resReg),
    .nextLsb_o (resNextLsb)
  );

  always_ff @(posedge SCK or posedge SRST) begin
    if (SRST) begin
      state_q     <= IR_IDLE;
      bitCnt_q    <= '0;
      ir_q        <= '0;
      cmd_q       <= '0;
      cmdUpdate_q <= 1'b0;
      frameErr_q  <= 1'b0;
      sdo_q       <= 1'b0;
    end else begin
      cmdUpdate_q <= 1'b0;
      frameErr_q  <= 1'b0;
      sdo_q       <= sdo_d;
      case (state_q)
        IR_IDLE: begin
          if (SEN) begin
            bitCnt_q <= CNT_W'(1);
            state_q  <= IR_SHIFT;
          end
        end
        IR_SHIFT: begin
          if (SEN) begin
            bitCnt_q <= bitCntInc;
          end else begin
            if (bitCnt_q == IR_LEN) begin
              ir_q <= irShadow;
            end else begin
              frameErr_q <= 1'b1;
            end
            bitCnt_q <= '0;
            state_q  <= DR_IDLE;
          end
        end
        DR_IDLE: begin
          if (SEN) begin
            bitCnt_q <= CNT_W'(1);
            state_q  <= DR_SHIFT;
          end
        end
        DR_SHIFT: begin
          if (SEN) begin
            bitCnt_q <= bitCntInc;
          end else begin
            // Only command frames have a fixed length; result and bypass frames may be any length.
            if (isCmd) begin
              if (bitCnt_q == CMD_LEN) begin
                cmd_q       <= cmdShadow;
                cmdUpdate_q <= 1'b1;
              end else begin
                frameErr_q <= 1'b1;
              end
            end
            bitCnt_q <= '0;
            state_q  <= IR_IDLE;
          end
        end
        default: state_q <= IR_IDLE;
      endcase
    end
  end

  assign SDO        = sdo_q;
  assign cmd_out    = cmd_q;
  assign cmd_update = cmdUpdate_q;
  assign ir_out     = ir_q;
  assign frame_err  = frameErr_q;

endmodule

// File: doc/mbist_serial_slave.md
Name: mbist_serial_slave

Overview:
- SCK-domain serial responder for the MBIST controller; the device-side end of the SEN/SDI/SDO scan protocol that the bench drives.
- Decodes an IR-select frame, then a data frame. A data frame either shifts a command word in (MEN) or shifts a result word out (MGO, MRD).
- Sits between the chip serial pins and the MBIST controller. MCK-domain synchronisation of cmd_out is the consumer's job.

Parameters:
- IR_WIDTH, 2, instruction register length in bits.
- CMD_WIDTH, 1, command register length in bits (bit0 = MEN).
- RESULT_WIDTH, 2, result register length in bits (bit0 = MGO, bit1 = MRD).
- COMMAND_IR_ID, 1, IR code that selects the command register.
- TEST_RESULT_IR_ID, 2, IR code that selects the result register.

Ports:
- SCK  input  1  serial clock; all state updates on the rising edge.
- SRST  input  1  asynchronous, active-high reset.
- SEN  input  1  shift enable; high marks an active frame.
- SDI  input  1  serial data in, LSB first.
- SDO  output  1  serial data out, LSB first.
- result_in  input  RESULT_WIDTH  live status from the MBIST controller.
- cmd_out  output  CMD_WIDTH  committed command register.
- cmd_update  output  1  one-cycle pulse when cmd_out is committed.
- ir_out  output  IR_WIDTH  current IR value.
- frame_err  output  1  one-cycle pulse on a wrong-length frame.

Behaviour:
- Reset values: cmd_out=0, cmd_update=0, ir_out=0, frame_err=0, SDO=0, state=IR_IDLE, bit counter=0.
- Inputs change on SCK falling edges; the block samples SEN and SDI on rising edges only.
- FSM states: IR_IDLE, IR_SHIFT, DR_IDLE, DR_SHIFT.
- IR_IDLE, SEN=1: shift SDI into IR shadow from MSB side (LSB arrives first), counter=1, go to IR_SHIFT.
- IR_SHIFT, SEN=1: keep shifting, counter+1 (saturating at IR_WIDTH+1).
- IR_SHIFT, SEN=0:
  - If counter==IR_WIDTH: ir_out<=shadow.
  - Otherwise: ir_out unchanged, pulse frame_err.
  - Either way, go to DR_IDLE.
- DR_IDLE, result IR: result shift register reloads from result_in every cycle, so SDO=result_in[0] is valid before the first shift edge.
- DR_IDLE, SEN=1: go to DR_SHIFT, counter=1. This is the first shift edge.
- DR_SHIFT, SEN=1: counter+1.
- Data phase, ir_out==COMMAND_IR_ID: SDI shifts into the CMD_WIDTH shadow; SDO=0.
- Data phase, ir_out==TEST_RESULT_IR_ID: the result register shifts right, MSB filled with 0; SDO=register LSB.
- Data phase, any other IR: 1-bit bypass, SDO=SDI delayed one SCK.
- DR_SHIFT, SEN=0 (frame end):
  - Command IR, counter==CMD_WIDTH: cmd_out<=shadow and cmd_update pulses in the same cycle.
  - Command IR, wrong length: cmd_out is held and frame_err pulses.
  - Result IR: over-shifting is legal (zeros shift out); under-shifting is legal; no error.
  - All cases return to IR_IDLE.
- SDO is registered. It changes only on rising edges or on reset.
- SRST mid-frame: immediate return to reset values. A partially shifted IR or command is discarded.
- A single-cycle SEN pulse is a 1-bit frame and obeys the length rules above.
- cmd_out is held indefinitely between committed updates.

Decomposition:
- Shared package holds: state encoding (2-bit localparams), default IR IDs, and width defaults, reused by the controller and by benches.
- One natural sub-module: mbist_serial_shreg, a parameterised shift register with load, shift and LSB output. Instance it for the IR, command and result registers.

Test Plan:
- Reset: assert SRST for 2 SCK -> all outputs 0, state IR_IDLE; deassert -> no output change.
- Shift IR=1 (bits 1,0), idle 5 cycles, shift command 1 -> cmd_out=1 with cmd_update pulsing one cycle after SEN falls; then command 0 -> cmd_out=0.
- result_in=2'b11 held; shift IR=2, idle 5 cycles, 2-bit data frame -> SDO reads 1 before edge 1 and 1 before edge 2, then 0 if over-shifted to 3 bits.
- result_in changes 2'b01->2'b11 during DR_IDLE -> the frame captures 2'b11 (latest value before the first edge); a change during DR_SHIFT does not alter the bits shifted out.
- 3-bit IR frame -> frame_err pulses and ir_out is unchanged; 2-bit command frame with CMD_WIDTH=1 -> frame_err pulses and cmd_out is held.
- IR=3 (bypass) with SDI pattern 1,0,1 -> SDO shows 1,0,1 delayed by one SCK; SRST asserted mid-frame -> next frame decodes as IR.
